mask_serializer: RTL

MASK_SERIALIZER -- requirements
Module: mask_serializer

---
 rtl/mask_pkg.sv | 19 +
 rtl/bit_timer.sv | 33 +++
 rtl/mask_serializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/mask_pkg.sv
// rtl/mask_pkg.sv - shared state encodings and default constants for the mask stage and serializer
package mask_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } ser_state_e;

  localparam int DEF_DATA_LEN   = 8;
  localparam int DEF_BIT_PERIOD = 4;
  localparam int DEF_MSB_FIRST  = 1;

  // One spare bit so a counter can hold its limit value without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - counts BIT_PERIOD enabled cycles and pulses tick_o on the last one
module bit_timer
  import mask_pkg::*;
#(
  parameter int BIT_PERIOD = DEF_BIT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = cnt_width(BIT_PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mask_serializer.sv
// rtl/mask_serializer.sv - shifts a captured masked word out one bit per BIT_PERIOD cycles
module mask_serializer
  import mask_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int BIT_PERIOD = DEF_BIT_PERIOD,
  parameter int MSB_FIRST  = DEF_MSB_FIRST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic                err_clr_i,
  output logic                ready_o,
  output logic                ser_o,
  output logic                ser_valid_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam int BCNT_W = cnt_width(DATA_LEN);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_LEN - 1);

  ser_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] shreg_q;
  logic [BCNT_W-1:0]   bit_cnt_q;
  logic                tick;
  logic                timer_en;
  logic                timer_clr;
  logic                out_bit;

  assign out_bit = (MSB_FIRST != 0) ? shreg_q[DATA_LEN-1] : shreg_q[0];

  bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    ser_valid_o = 1'b0;
    done_o      = 1'b0;
    timer_en    = 1'b0;
    timer_clr   = 1'b1;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (load_i) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_valid_o = 1'b1;
        timer_en    = 1'b1;
        timer_clr   = 1'b0;
        if (tick && (bit_cnt_q == LAST_BIT)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ser_o = ser_valid_o & out_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && load_i) begin
      shreg_q   <= data_i;
      bit_cnt_q <= '0;
    end else if ((state_q == S_SHIFT) && tick) begin
      bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
      shreg_q   <= (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  // A late load sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_o <= 1'b0;
    end else if (load_i && (state_q != S_IDLE)) begin
      overrun_o <= 1'b1;
    end else if (err_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule
